// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: shared types, tap indexing and counter saturation helpers
package pipe_stage_chain_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_KILL
    } stage_act_e;

    localparam int CNT_W_MAX = 64;

    function automatic int tap_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // For w == CNT_W_MAX the shift wraps to zero and the subtraction still yields all ones.
    function automatic logic [CNT_W_MAX-1:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: input stream, per-stage controls, taps and counters of the chain
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic [DEPTH-1:0]       hold;
    logic [DEPTH-1:0]       flush;
    logic                   in_accept;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]       stage_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic [CNT_W-1:0]       bubble_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        output in_data, in_valid, hold, flush,
        input  in_accept, stage_data, stage_valid, out_data, out_valid, bubble_cnt, flush_cnt
    );

    modport slave (
        input  in_data, in_valid, hold, flush,
        output in_accept, stage_data, stage_valid, out_data, out_valid, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_chain_reg.sv
// pipe_stage_reg: one payload register with valid bit; kill beats hold beats bubble beats load
module pipe_stage_reg
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CLEAR_ON_KILL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             hold,
    input  logic             bubble,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    stage_act_e       act;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        act     = kill ? ACT_KILL : hold ? ACT_HOLD : bubble ? ACT_KILL : load ? ACT_LOAD : ACT_HOLD;
        valid_d = act == ACT_LOAD ? v_in : act == ACT_HOLD ? valid_q : 1'b0;
        data_d  = act == ACT_LOAD ? d_in : (act == ACT_KILL && CLEAR_ON_KILL != 0) ? '0 : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage register chain with hold backpressure, bubbles, flushes and event counters
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 4,
    parameter int CLEAR_ON_KILL = 1,
    parameter int CNT_W         = 16
) (
    input logic                clk,
    input logic                reset,
    pipe_stage_chain_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));

    logic [DEPTH-1:0] eh;
    logic [DEPTH-1:0] bubble_ev;
    logic [WIDTH-1:0] data_a [DEPTH];
    logic             valid_a [DEPTH];
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        logic             bub;
        // Suffix OR keeps each eh bit a pure function of hold.
        assign eh[i] = |bus.hold[DEPTH-1:i];
        if (i == 0) begin : g_head
            assign d_in = bus.in_data;
            assign v_in = bus.in_valid;
            assign bub  = 1'b0;
        end else begin : g_body
            assign d_in = data_a[i-1];
            assign v_in = valid_a[i-1];
            assign bub  = eh[i-1];
        end
        assign bubble_ev[i] = bub & ~eh[i] & ~bus.flush[i];
        pipe_stage_reg #(
            .WIDTH         (WIDTH),
            .CLEAR_ON_KILL (CLEAR_ON_KILL)
        ) u_reg (
            .clk    (clk),
            .reset  (reset),
            .kill   (bus.flush[i]),
            .hold   (eh[i]),
            .bubble (bub),
            .load   (~eh[i]),
            .d_in   (d_in),
            .v_in   (v_in),
            .data   (data_a[i]),
            .valid  (valid_a[i])
        );
        assign bus.stage_data[tap_lo(i, WIDTH) +: WIDTH] = data_a[i];
        assign bus.stage_valid[i]                         = valid_a[i];
    end

    always_comb begin
        bubble_cnt_d = (|bubble_ev && bubble_cnt_q != CNT_SAT) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
        flush_cnt_d  = (|bus.flush && flush_cnt_q != CNT_SAT) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.in_accept  = ~eh[0];
    assign bus.out_data   = data_a[DEPTH-1];
    assign bus.out_valid  = valid_a[DEPTH-1];
    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: table-driven checks of the chain plus saturation and keep-on-kill sequences
module tb_pipe_stage_chain;
    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) bus_a ();
    pipe_stage_chain_if #(.WIDTH(8), .DEPTH(4), .CNT_W(2))  bus_b ();

    pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .CLEAR_ON_KILL(1), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .CLEAR_ON_KILL(0), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    typedef struct packed {
        logic        rst;
        logic [7:0]  d;
        logic        v;
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic        acc;
        logic [31:0] sd;
        logic [3:0]  sv;
        logic [15:0] bc;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_b(input logic r, input logic [7:0] d, input logic v, input logic [3:0] h, input logic [3:0] f);
        @(negedge clk);
        reset_b        = r;
        bus_b.in_data  = d;
        bus_b.in_valid = v;
        bus_b.hold     = h;
        bus_b.flush    = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 8'h11, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h00000011, 4'b0001, 16'd0, 16'd0};
        vecs[2]  = '{1'b0, 8'h22, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h00001122, 4'b0011, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 8'h33, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h00112233, 4'b0111, 16'd0, 16'd0};
        vecs[4]  = '{1'b0, 8'h44, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h11223344, 4'b1111, 16'd0, 16'd0};
        vecs[5]  = '{1'b0, 8'h55, 1'b1, 4'b0010, 4'b0000, 1'b0, 32'h22003344, 4'b1011, 16'd1, 16'd0};
        vecs[6]  = '{1'b0, 8'h55, 1'b1, 4'b0000, 4'b0001, 1'b1, 32'h00334400, 4'b0110, 16'd1, 16'd1};
        vecs[7]  = '{1'b0, 8'h66, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h33440066, 4'b1101, 16'd1, 16'd1};
        vecs[8]  = '{1'b0, 8'h77, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h44006677, 4'b1011, 16'd1, 16'd1};
        vecs[9]  = '{1'b0, 8'h88, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h00667788, 4'b0111, 16'd1, 16'd1};
        vecs[10] = '{1'b0, 8'h99, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h66778899, 4'b1111, 16'd1, 16'd1};
        vecs[11] = '{1'b0, 8'hAA, 1'b1, 4'b0100, 4'b0100, 1'b0, 32'h00008899, 4'b0011, 16'd2, 16'd2};
        vecs[12] = '{1'b0, 8'hBB, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h008899BB, 4'b0110, 16'd2, 16'd2};
        vecs[13] = '{1'b0, 8'hCC, 1'b1, 4'b1000, 4'b0000, 1'b0, 32'h008899BB, 4'b0110, 16'd2, 16'd2};
        vecs[14] = '{1'b0, 8'hDD, 1'b1, 4'b0001, 4'b0001, 1'b0, 32'h88990000, 4'b1100, 16'd3, 16'd3};
        vecs[15] = '{1'b1, 8'hEE, 1'b1, 4'b1111, 4'b1111, 1'b0, 32'h00000000, 4'b0000, 16'd0, 16'd0};

        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.hold = '0; bus_a.flush = '0;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.hold = '0; bus_b.flush = '0;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            reset_a        = vecs[k].rst;
            bus_a.in_data  = vecs[k].d;
            bus_a.in_valid = vecs[k].v;
            bus_a.hold     = vecs[k].hold;
            bus_a.flush    = vecs[k].flush;
            #1;
            chk($sformatf("v%0d in_accept", k), 64'(bus_a.in_accept), 64'(vecs[k].acc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d stage_data", k), 64'(bus_a.stage_data), 64'(vecs[k].sd));
            chk($sformatf("v%0d stage_valid", k), 64'(bus_a.stage_valid), 64'(vecs[k].sv));
            chk($sformatf("v%0d out_data", k), 64'(bus_a.out_data), 64'(vecs[k].sd[31:24]));
            chk($sformatf("v%0d out_valid", k), 64'(bus_a.out_valid), 64'(vecs[k].sv[3]));
            chk($sformatf("v%0d bubble_cnt", k), 64'(bus_a.bubble_cnt), 64'(vecs[k].bc));
            chk($sformatf("v%0d flush_cnt", k), 64'(bus_a.flush_cnt), 64'(vecs[k].fc));
        end

        // Keep-on-kill chain with a 2-bit bubble counter.
        drive_b(1'b1, 8'h00, 1'b0, 4'b0000, 4'b0000);
        chk("b reset valid", 64'(bus_b.stage_valid), 64'h0);
        chk("b reset bubble_cnt", 64'(bus_b.bubble_cnt), 64'h0);
        drive_b(1'b0, 8'hA1, 1'b1, 4'b0000, 4'b0000);
        drive_b(1'b0, 8'hA2, 1'b1, 4'b0000, 4'b0000);
        drive_b(1'b0, 8'hA3, 1'b1, 4'b0000, 4'b0000);
        drive_b(1'b0, 8'hA4, 1'b1, 4'b0000, 4'b0000);
        chk("b full data", 64'(bus_b.stage_data), 64'hA1A2A3A4);
        drive_b(1'b0, 8'hB1, 1'b1, 4'b0001, 4'b0000);
        chk("b bubble1 data", 64'(bus_b.stage_data), 64'hA2A3A3A4);
        chk("b bubble1 valid", 64'(bus_b.stage_valid), 64'b1101);
        chk("b bubble1 cnt", 64'(bus_b.bubble_cnt), 64'd1);
        drive_b(1'b0, 8'hB2, 1'b1, 4'b0001, 4'b0000);
        drive_b(1'b0, 8'hB3, 1'b1, 4'b0001, 4'b0000);
        chk("b bubble3 cnt", 64'(bus_b.bubble_cnt), 64'd3);
        drive_b(1'b0, 8'hB4, 1'b1, 4'b0001, 4'b0000);
        drive_b(1'b0, 8'hB5, 1'b1, 4'b0001, 4'b0000);
        chk("b bubble5 cnt sat", 64'(bus_b.bubble_cnt), 64'd3);
        chk("b bubble5 data", 64'(bus_b.stage_data), 64'hA3A3A3A4);
        chk("b bubble5 valid", 64'(bus_b.stage_valid), 64'b0001);
        drive_b(1'b0, 8'hC5, 1'b1, 4'b0000, 4'b0001);
        chk("b flush keep data", 64'(bus_b.stage_data), 64'hA3A3A4A4);
        chk("b flush valid", 64'(bus_b.stage_valid), 64'b0010);
        chk("b flush_cnt", 64'(bus_b.flush_cnt), 64'd1);
        chk("b flush no bubble", 64'(bus_b.bubble_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
